// File: rtl/keypad_scan_debounce.sv
// Row-scanned matrix keypad with column synchroniser, press/release debounce and hold status.
// Optional macro KEYPAD_HEX_MAP_EN maps accepted keys to the 4x4 hex pad legend instead of r*COLS+c.
module keypad_scan_debounce #(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned SETTLE_CYCLES   = 1024,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CODE_W          = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [COLS-1:0]   col,
  output logic [ROWS-1:0]   row,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_held,
  output logic              multi_err
);

  localparam int unsigned CNT_MAX = (SETTLE_CYCLES > DEBOUNCE_CYCLES) ? SETTLE_CYCLES : DEBOUNCE_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;
  localparam int unsigned RIDX_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CIDX_W  = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RIDX_W-1:0] ROW_LAST    = RIDX_W'(ROWS - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  if ((2 ** CODE_W) < (ROWS * COLS)) begin : g_code_w_check
    $error("CODE_W too narrow for ROWS*COLS keys");
  end

`ifdef KEYPAD_HEX_MAP_EN
  if (ROWS != 4 || COLS != 4 || CODE_W != 4) begin : g_hex_map_check
    $error("KEYPAD_HEX_MAP_EN requires ROWS=4, COLS=4, CODE_W=4");
  end

  // Legend of the 4x4 pad, indexed by r*4+c
  function automatic logic [3:0] hex_legend(input logic [3:0] idx);
    case (idx)
      4'd0:    return 4'h1;
      4'd1:    return 4'h2;
      4'd2:    return 4'h3;
      4'd3:    return 4'hA;
      4'd4:    return 4'h4;
      4'd5:    return 4'h5;
      4'd6:    return 4'h6;
      4'd7:    return 4'hB;
      4'd8:    return 4'h7;
      4'd9:    return 4'h8;
      4'd10:   return 4'h9;
      4'd11:   return 4'hC;
      4'd12:   return 4'hE;
      4'd13:   return 4'h0;
      4'd14:   return 4'hF;
      default: return 4'hD;
    endcase
  endfunction
`endif

  logic [COLS-1:0]   r_col_m;
  logic [COLS-1:0]   r_col_s;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RIDX_W-1:0] r_row_idx;
  logic [ROWS-1:0]   r_row;
  logic [COLS-1:0]   r_pat;
  logic [RIDX_W-1:0] r_hit_row;
  logic [CIDX_W-1:0] r_hit_col;
  logic [CODE_W-1:0] r_key_code;
  logic              r_key_valid;
  logic              r_key_held;
  logic              r_multi_err;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [RIDX_W-1:0] w_row_idx_nxt;
  logic [ROWS-1:0]   w_row_nxt;
  logic [COLS-1:0]   w_pat_nxt;
  logic [RIDX_W-1:0] w_hit_row_nxt;
  logic [CIDX_W-1:0] w_hit_col_nxt;
  logic [CODE_W-1:0] w_key_code_nxt;
  logic              w_key_valid_nxt;
  logic              w_key_held_nxt;
  logic              w_multi_err_nxt;

  logic              w_col_any;
  logic              w_col_onehot;
  logic [CIDX_W-1:0] w_col_idx;
  logic [RIDX_W-1:0] w_row_idx_inc;
  logic [CODE_W-1:0] w_code_lin;
  logic [CODE_W-1:0] w_code_map;

  // Two-flop synchroniser on the raw column pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_col_m <= '0;
      r_col_s <= '0;
    end else begin
      r_col_m <= col;
      r_col_s <= r_col_m;
    end
  end

  assign w_col_any     = (r_col_s != '0);
  assign w_col_onehot  = w_col_any && ((r_col_s & (r_col_s - COLS'(1))) == '0);
  assign w_row_idx_inc = (r_row_idx == ROW_LAST) ? '0 : r_row_idx + RIDX_W'(1);
  assign w_code_lin    = CODE_W'(32'(r_hit_row) * COLS + 32'(r_hit_col));

`ifdef KEYPAD_HEX_MAP_EN
  assign w_code_map = CODE_W'(hex_legend(4'(w_code_lin)));
`else
  assign w_code_map = w_code_lin;
`endif

  // Column index of a one-hot sample
  always_comb begin
    w_col_idx = '0;
    for (int i = 0; i < COLS; i++) begin
      if (r_col_s[i]) w_col_idx = CIDX_W'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_row_idx   <= '0;
      r_row       <= ROWS'(1);
      r_pat       <= '0;
      r_hit_row   <= '0;
      r_hit_col   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_row       <= w_row_nxt;
      r_pat       <= w_pat_nxt;
      r_hit_row   <= w_hit_row_nxt;
      r_hit_col   <= w_hit_col_nxt;
      r_key_code  <= w_key_code_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
      r_multi_err <= w_multi_err_nxt;
    end
  end

  // Next-state and output logic; row drive only moves in SCAN or when leaving a key
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_row_idx_nxt   = r_row_idx;
    w_row_nxt       = r_row;
    w_pat_nxt       = r_pat;
    w_hit_row_nxt   = r_hit_row;
    w_hit_col_nxt   = r_hit_col;
    w_key_code_nxt  = r_key_code;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    w_multi_err_nxt = 1'b0;

    case (r_state)
      ST_SCAN: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt_nxt = '0;
          if (w_col_onehot) begin
            w_pat_nxt     = r_col_s;
            w_hit_row_nxt = r_row_idx;
            w_hit_col_nxt = w_col_idx;
            w_state_nxt   = ST_PRESS_DB;
          end else begin
            w_multi_err_nxt = w_col_any;
            w_row_idx_nxt   = w_row_idx_inc;
            w_row_nxt       = ROWS'(1) << w_row_idx_inc;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_PRESS_DB: begin
        if (r_col_s != r_pat) begin
          w_cnt_nxt     = '0;
          w_state_nxt   = ST_SCAN;
          w_row_idx_nxt = w_row_idx_inc;
          w_row_nxt     = ROWS'(1) << w_row_idx_inc;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nxt       = '0;
          w_key_code_nxt  = w_code_map;
          w_key_valid_nxt = 1'b1;
          w_key_held_nxt  = 1'b1;
          w_state_nxt     = ST_HELD;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_HELD: begin
        if (!w_col_any) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_REL_DB;
        end
      end

      ST_REL_DB: begin
        // Any activity during release is bounce on the held key, not a new press
        if (w_col_any) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_HELD;
        end else if (r_cnt == DEB_LAST) begin
          w_cnt_nxt      = '0;
          w_key_held_nxt = 1'b0;
          w_state_nxt    = ST_SCAN;
          w_row_idx_nxt  = w_row_idx_inc;
          w_row_nxt      = ROWS'(1) << w_row_idx_inc;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  assign row       = r_row;
  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign multi_err = r_multi_err;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: behavioural keypad model driving col from row, key codes checked via scoreboard.
module tb_keypad_scan_debounce;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned SETTLE = 4;
  localparam int unsigned DEB    = 8;
  localparam int unsigned CODE_W = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [COLS-1:0]   col;
  logic [ROWS-1:0]   row;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_held;
  logic              multi_err;

  int errors = 0;
  int checks = 0;
  logic [CODE_W-1:0] sb[$];
  logic [CODE_W-1:0] mon_exp;

  // Keypad model: a pressed key connects its row line to its column(s)
  logic            kp_en = 1'b0;
  logic            kp_bounce = 1'b0;
  logic [1:0]      kp_row = 2'd0;
  logic [COLS-1:0] kp_mask = '0;

  always #5 clk = ~clk;

  always_comb begin
    col = '0;
    if (kp_en && !kp_bounce && row[kp_row]) col = kp_mask;
  end

  keypad_scan_debounce #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE_CYCLES(SETTLE), .DEBOUNCE_CYCLES(DEB), .CODE_W(CODE_W)
  ) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err)
  );

  function automatic logic [CODE_W-1:0] exp_code(input int r, input int c);
`ifdef KEYPAD_HEX_MAP_EN
    logic [3:0] lg [16];
    lg = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
           4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};
    return lg[r * 4 + c];
`else
    return CODE_W'(r * COLS + c);
`endif
  endfunction

  // Scoreboard consumer: every key_valid pulse must match a queued expectation
  always @(negedge clk) begin
    if (!reset && key_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL key_valid_unexpected: pulse with code=%0h, required no pulse", key_code);
      end else begin
        mon_exp = sb.pop_front();
        if (key_code !== mon_exp) begin
          errors++;
          $display("FAIL key_code: got %0h, required %0h", key_code, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  // Wait for the start of a fresh dwell on target row
  task automatic wait_row(input logic [ROWS-1:0] target, output bit ok);
    int n = 0;
    while (row === target && n < 100) begin @(negedge clk); n++; end
    while (row !== target && n < 100) begin @(negedge clk); n++; end
    ok = (row === target);
  endtask

  task automatic wait_held(input logic v, input int budget, output int n);
    n = 0;
    while (key_held !== v && n < budget) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    kp_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL reset_row: got %b, required 0001", row); end
    checks++; if (key_code !== '0) begin errors++; $display("FAIL reset_code: got %0h, required 0", key_code); end
    checks++; if ({key_valid, key_held, multi_err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b, required 000", {key_valid, key_held, multi_err});
    end
  endtask

  task automatic test_idle();
    logic [ROWS-1:0] prev;
    int run = 0;
    int changes = 0;
    bit quiet = 1'b1;
    reset = 1'b0;
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL idle_first_row: got %b, required 0001", row); end
    prev = row;
    for (int k = 0; k < 100; k++) begin
      if (row !== prev) begin
        checks++; if (run != SETTLE) begin errors++; $display("FAIL idle_dwell: got %0d cycles, required %0d", run, SETTLE); end
        checks++; if (row !== {prev[ROWS-2:0], prev[ROWS-1]}) begin
          errors++; $display("FAIL idle_order: got %b after %b", row, prev);
        end
        prev = row; run = 0; changes++;
      end
      run++;
      if (key_valid !== 1'b0 || key_held !== 1'b0 || multi_err !== 1'b0) quiet = 1'b0;
      @(negedge clk);
    end
    checks++; if (changes != 100 / SETTLE - 1) begin errors++; $display("FAIL idle_changes: got %0d, required %0d", changes, 100 / SETTLE - 1); end
    checks++; if (!quiet) begin errors++; $display("FAIL idle_quiet: got activity on valid/held/multi_err, required none"); end
  endtask

  task automatic test_press();
    bit ok;
    bit frozen = 1'b1;
    int n;
    kp_row = 2'd2; kp_mask = 4'b0010; kp_en = 1'b1;
    sb.push_back(exp_code(2, 1));
    wait_row(4'b0100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL press_reach_row: got row %b, required 0100", row); end
    for (int k = 0; k < 40; k++) begin
      if (row !== 4'b0100) frozen = 1'b0;
      @(negedge clk);
    end
    checks++; if (!frozen) begin errors++; $display("FAIL press_row_frozen: got row %b during hold, required 0100", row); end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL press_held: got %b, required 1", key_held); end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL press_pulse_missing: got %0d pending, required 0", sb.size()); end
    kp_en = 1'b0;
    wait_held(1'b0, 40, n);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL press_release: got held %b, required 0", key_held); end
    checks++; if (row !== 4'b1000) begin errors++; $display("FAIL press_next_row: got %b, required 1000", row); end
  endtask

  task automatic test_press_bounce();
    bit ok;
    int n;
    kp_row = 2'd2; kp_mask = 4'b0010; kp_en = 1'b1;
    wait_row(4'b0100, ok);
    repeat (5) @(negedge clk);
    kp_bounce = 1'b1;
    repeat (3) @(negedge clk);
    kp_bounce = 1'b0;
    checks++; if (row !== 4'b1000) begin errors++; $display("FAIL bounce_scan_resume: got %b, required 1000", row); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_held: got %b, required 0", key_held); end
    sb.push_back(exp_code(2, 1));
    wait_row(4'b0100, ok);
    repeat (30) @(negedge clk);
    checks++; if (sb.size() != 0 || key_held !== 1'b1) begin
      errors++; $display("FAIL bounce_later_press: got pending=%0d held=%b, required 0 and 1", sb.size(), key_held);
    end
    kp_en = 1'b0;
    wait_held(1'b0, 40, n);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL bounce_release: got held %b, required 0", key_held); end
  endtask

  task automatic test_release_bounce();
    bit ok;
    int n;
    kp_row = 2'd2; kp_mask = 4'b0010; kp_en = 1'b1;
    sb.push_back(exp_code(2, 1));
    wait_row(4'b0100, ok);
    repeat (20) @(negedge clk);
    checks++; if (key_held !== 1'b1 || sb.size() != 0) begin
      errors++; $display("FAIL relb_accept: got held=%b pending=%0d, required 1 and 0", key_held, sb.size());
    end
    for (int b = 0; b < 2; b++) begin
      kp_en = 1'b0; repeat (3) @(negedge clk);
      kp_en = 1'b1; repeat (3) @(negedge clk);
    end
    checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL relb_held_through_bounce: got %b, required 1", key_held); end
    kp_en = 1'b0;
    wait_held(1'b0, 30, n);
    // DEB stable cycles after the edge, plus synchroniser and decision latency
    checks++; if (n < DEB || n > DEB + 4) begin
      errors++; $display("FAIL relb_held_fall: got %0d cycles, required %0d..%0d", n, DEB, DEB + 4);
    end
    checks++; if (row !== 4'b1000) begin errors++; $display("FAIL relb_next_row: got %b, required 1000", row); end
  endtask

  task automatic test_multi();
    bit ok;
    int pulses = 0;
    logic [ROWS-1:0] row_at = '0;
    kp_row = 2'd0; kp_mask = 4'b0011; kp_en = 1'b1;
    wait_row(4'b0001, ok);
    for (int k = 0; k < 8; k++) begin
      if (multi_err === 1'b1) begin pulses++; row_at = row; end
      @(negedge clk);
    end
    kp_en = 1'b0;
    checks++; if (pulses != 1) begin errors++; $display("FAIL multi_pulses: got %0d, required 1", pulses); end
    checks++; if (row_at !== 4'b0010) begin errors++; $display("FAIL multi_advance: got %b, required 0010", row_at); end
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL multi_held: got %b, required 0", key_held); end
  endtask

  task automatic test_reset_held();
    bit ok;
    int n;
    kp_row = 2'd2; kp_mask = 4'b0010; kp_en = 1'b1;
    sb.push_back(exp_code(2, 1));
    wait_row(4'b0100, ok);
    repeat (20) @(negedge clk);
    checks++; if (key_held !== 1'b1 || sb.size() != 0) begin
      errors++; $display("FAIL rsth_accept: got held=%b pending=%0d, required 1 and 0", key_held, sb.size());
    end
    reset = 1'b1;
    #1;
    checks++; if (row !== 4'b0001) begin errors++; $display("FAIL rsth_row: got %b, required 0001", row); end
    checks++; if (key_code !== '0) begin errors++; $display("FAIL rsth_code: got %0h, required 0", key_code); end
    checks++; if (key_held !== 1'b0 || key_valid !== 1'b0) begin
      errors++; $display("FAIL rsth_flags: got held=%b valid=%b, required 0 0", key_held, key_valid);
    end
    @(negedge clk);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rsth_early_held: got %b, required 0", key_held); end
    sb.push_back(exp_code(2, 1));
    n = 0;
    while (sb.size() != 0 && n < 40) begin @(negedge clk); n++; end
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL rsth_reaccept: got %0d pending, required 0", sb.size()); end
    kp_en = 1'b0;
    wait_held(1'b0, 40, n);
    checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL rsth_release: got held %b, required 0", key_held); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_press();
    test_press_bounce();
    test_release_bounce();
    test_multi();
    test_reset_held();
    repeat (4) @(negedge clk);
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL final_scoreboard: got %0d pending, required 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
